// File: rtl/muldiv_pkg.sv
// Shared encodings and operand-signedness helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction and result-half/quotient-remainder selection for the FIX state.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              op_i,
  input  logic                    neg_a_i,
  input  logic                    neg_b_i,
  input  logic                    special_i,
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   quot_i,
  input  logic [DATA_WIDTH-1:0]   rem_i,
  output logic [DATA_WIDTH-1:0]   res_o
);
  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  always_comb begin
    prod = (neg_a_i ^ neg_b_i) ? -acc_i : acc_i;
    quot = (neg_a_i ^ neg_b_i) ? -quot_i : quot_i;
    rem  = neg_a_i ? -rem_i : rem_i;
    // Special cases arrive with final quotient/remainder already loaded; no correction.
    case (op_i)
      OP_MUL:                       res_o = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              res_o = special_i ? quot_i : quot;
      default:                      res_o = special_i ? rem_i : rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine (radix-2 shift-add / restoring divide) with kill and tag.
// Optional MULDIV_EARLY_OUT_EN: trivial mul (zero operand) and div (|a|<|b|) skip the iterations.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 5,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  kill_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  busy_o
);
  localparam int W = DATA_WIDTH;

  logic [1:0]           state_q, state_d;
  logic [2:0]           op_q;
  logic [TAG_WIDTH-1:0] tag_q, tag_out_q;
  logic                 neg_a_q, neg_b_q, special_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         opnd_q, quot_q, rem_q, res_q;
  logic [2*W-1:0]       acc_q;

  logic         na, nb, div_zero, div_ovf, early, accept;
  logic [W-1:0] mag_a, mag_b, fix_res;

  always_comb begin
    na       = is_signed_a(op_i) & a_i[W-1];
    nb       = is_signed_b(op_i) & b_i[W-1];
    mag_a    = na ? -a_i : a_i;
    mag_b    = nb ? -b_i : b_i;
    div_zero = is_div(op_i) && (b_i == '0);
    div_ovf  = is_div(op_i) && is_signed_a(op_i) && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early    = is_div(op_i) ? (mag_a < mag_b) : ((a_i == '0) || (b_i == '0));
`else
    early    = 1'b0;
`endif
    accept   = (state_q == ST_IDLE) && in_valid_i && !kill_i;
  end

  // One iteration of either algorithm; opnd_q holds |a| for mul, |b| for div.
  logic [W:0]     hi_sum, shifted, trial;
  logic [2*W-1:0] acc_step;
  logic [W-1:0]   rem_step, quot_step;

  always_comb begin
    hi_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_step  = {hi_sum, acc_q[W-1:1]};
    shifted   = {rem_q, quot_q[W-1]};
    trial     = shifted - {1'b0, opnd_q};
    rem_step  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    quot_step = {quot_q[W-2:0], ~trial[W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i) state_d = (div_zero || div_ovf || early) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt_q == CNT_WIDTH'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: if (out_ready_i) state_d = ST_IDLE;
    endcase
    if (kill_i) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      res_q     <= '0;
    end else if (accept) begin
      op_q      <= op_i;
      tag_q     <= tag_i;
      neg_a_q   <= na;
      neg_b_q   <= nb;
      special_q <= div_zero || div_ovf;
      cnt_q     <= CNT_WIDTH'(W);
      opnd_q    <= is_div(op_i) ? mag_b : mag_a;
      acc_q     <= {{W{1'b0}}, mag_b};
      quot_q    <= mag_a;
      rem_q     <= '0;
      if (div_zero) begin
        quot_q <= '1;
        rem_q  <= a_i;
      end else if (div_ovf) begin
        quot_q <= a_i;
        rem_q  <= '0;
      end else if (early) begin
        acc_q  <= '0;
        quot_q <= '0;
        rem_q  <= mag_a;
      end
    end else if (state_q == ST_CALC && !kill_i) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (is_div(op_q)) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
      end else begin
        acc_q  <= acc_step;
      end
    end else if (state_q == ST_FIX && !kill_i) begin
      res_q     <= fix_res;
      tag_out_q <= tag_q;
    end
  end

  muldiv_signfix #(.DATA_WIDTH(W)) u_signfix (
    .op_i      (op_q),
    .neg_a_i   (neg_a_q),
    .neg_b_i   (neg_b_q),
    .special_i (special_q),
    .acc_i     (acc_q),
    .quot_i    (quot_q),
    .rem_i     (rem_q),
    .res_o     (fix_res)
  );

  assign res_o = res_q;
  assign tag_o = tag_out_q;

endmodule
